// File: rtl/imem_ldr_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the loader state encoding and the stream framing widths.
package imem_ldr_pkg;

   localparam int LEN_W  = 16;
   localparam int LANES  = 4;
   localparam int LANE_W = $clog2(LANES);

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      WRITE,
      DONE,
      ERR
   } ldr_state_e;

endpackage

// File: rtl/byte_word_asm.sv
// Little-endian byte-to-word assembler: a lane counter plus a lane-insert register.
// word_o already includes the byte being pushed, so the caller can latch a full word on word_full_o.
module byte_word_asm
   import imem_ldr_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        push_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_full_o
);

   logic [LANE_W-1:0] lane_q, lane_d;
   logic [31:0]       word_q, word_d;

   always_comb begin
      lane_d = lane_q;
      word_d = word_q;
      if (clear_i) begin
         lane_d = '0;
         word_d = '0;
      end else if (push_i) begin
         word_d[{lane_q, 3'b000} +: 8] = byte_i;
         lane_d = lane_q + 1'b1;
      end
   end

   assign word_o      = word_d;
   assign word_full_o = push_i && !clear_i && (lane_q == LANE_W'(LANES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         lane_q <= '0;
         word_q <= '0;
      end else begin
         lane_q <= lane_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction RAM writer: parses a length-prefixed byte stream and writes
// one little-endian word per WRITE cycle at consecutive addresses, holding the CPU until done.
module imem_loader
   import imem_ldr_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_ldr_i,
   input  logic             byte_valid_ldr_i,
   input  logic [7:0]       byte_ldr_i,
   output logic             byte_ready_ldr_o,
   output logic [31:0]      addr_imem_ram_o,
   output logic [31:0]      wr_instr_imem_ram_o,
   output logic             wr_en_imem_ram_o,
   output logic [LEN_W-1:0] words_written_ldr_o,
   output logic             busy_ldr_o,
   output logic             done_ldr_o,
   output logic             err_ldr_o,
   output logic             cpu_hold_ldr_o,
   output ldr_state_e       state_dbg_o
);

   localparam logic [31:0] MAX_W = MAX_WORDS;

   ldr_state_e       state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      data_q, data_d;

   logic             xfer;
   logic             start_ok;
   logic [LEN_W-1:0] len_full;
   logic [31:0]      asm_word;
   logic             asm_full;

   assign xfer     = byte_valid_ldr_i && byte_ready_ldr_o;
   assign start_ok = start_ldr_i && (state_q inside {IDLE, DONE, ERR});
   assign len_full = {byte_ldr_i, len_q[7:0]};

   byte_word_asm u_asm (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (start_ok),
      .push_i      (xfer && (state_q == DATA)),
      .byte_i      (byte_ldr_i),
      .word_o      (asm_word),
      .word_full_o (asm_full)
   );

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start_ok) begin
               state_d = LEN_LO;
               idx_d   = '0;
            end
         end
         LEN_LO: begin
            if (xfer) begin
               len_d[7:0] = byte_ldr_i;
               state_d    = LEN_HI;
            end
         end
         LEN_HI: begin
            if (xfer) begin
               len_d = len_full;
               if (len_full == '0)                  state_d = DONE;
               else if ({16'h0, len_full} > MAX_W)  state_d = ERR;
               else                                 state_d = DATA;
            end
         end
         DATA: begin
            // Address and word are captured here so they are stable for the whole WRITE cycle.
            if (asm_full) begin
               state_d = WRITE;
               addr_d  = BASE_ADDR + {14'h0, idx_q, 2'b00};
               data_d  = asm_word;
            end
         end
         WRITE: begin
            idx_d = idx_q + 1'b1;
            if ((idx_q + 1'b1) == len_q) state_d = DONE;
            else                         state_d = DATA;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Handshake: a byte moves on a rising edge where byte_valid_ldr_i and byte_ready_ldr_o are both 1;
   // ready depends on state only, never on valid.
   assign byte_ready_ldr_o    = state_q inside {LEN_LO, LEN_HI, DATA};
   assign wr_en_imem_ram_o    = (state_q == WRITE);
   assign addr_imem_ram_o     = addr_q;
   assign wr_instr_imem_ram_o = data_q;
   assign words_written_ldr_o = idx_q;
   assign busy_ldr_o          = state_q inside {LEN_LO, LEN_HI, DATA, WRITE};
   assign done_ldr_o          = (state_q == DONE);
   assign err_ldr_o           = (state_q == ERR);
   assign cpu_hold_ldr_o      = (state_q != DONE);
   assign state_dbg_o         = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized programs
// compared against an address/word list built from the stream format.
module tb_imem_loader;
   import imem_ldr_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        bvalid;
   logic [7:0]  bdata;
   logic        bready;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        wr_en;
   logic [15:0] words;
   logic        busy, done, err, hold;
   ldr_state_e  state_dbg;

   imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(1024)) dut (
      .clk                 (clk),
      .reset               (reset),
      .start_ldr_i         (start),
      .byte_valid_ldr_i    (bvalid),
      .byte_ldr_i          (bdata),
      .byte_ready_ldr_o    (bready),
      .addr_imem_ram_o     (addr),
      .wr_instr_imem_ram_o (wdata),
      .wr_en_imem_ram_o    (wr_en),
      .words_written_ldr_o (words),
      .busy_ldr_o          (busy),
      .done_ldr_o          (done),
      .err_ldr_o           (err),
      .cpu_hold_ldr_o      (hold),
      .state_dbg_o         (state_dbg)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_cmp = 0;
   int n_fail = 0;

   logic [63:0] exp_q[$];
   logic [63:0] obs_q[$];
   int          obs_cyc[$];
   int          word_end_q[$];
   logic [31:0] prog_q[$];
   int          xfer_cyc;

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         obs_q.push_back({addr, wdata});
         obs_cyc.push_back(cyc);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic clear_sb();
      exp_q.delete(); obs_q.delete(); obs_cyc.delete(); word_end_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int t;
      if (gap) begin
         bvalid = 1'b0;
         @(negedge clk);
      end
      bvalid = 1'b1;
      bdata  = b;
      t = 0;
      while (bready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         n_cmp++; n_fail++;
         $display("FAIL byte_handshake: ready=%b after %0d cycles, required 1", bready, t);
      end else begin
         @(negedge clk);
         xfer_cyc = cyc;
      end
   endtask

   // Sends header + all words in prog_q and fills the expected write list.
   task automatic send_program(input bit gap, input bit rnd_gap);
      logic [15:0] n;
      logic [31:0] w;
      n = 16'(prog_q.size());
      send_byte(n[7:0], gap || (rnd_gap && $urandom_range(0, 1) == 1));
      send_byte(n[15:8], gap || (rnd_gap && $urandom_range(0, 1) == 1));
      for (int i = 0; i < prog_q.size(); i++) begin
         w = prog_q[i];
         exp_q.push_back({BASE + 32'(4 * i), w});
         for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8], gap || (rnd_gap && $urandom_range(0, 1) == 1));
         word_end_q.push_back(xfer_cyc);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      start = 1'b0; bvalid = 1'b0; bdata = 8'h00;
      do_reset(3);
      n_cmp++;
      if ({bready, wr_en, busy, done, err, hold} !== 6'b000001) begin
         n_fail++;
         $display("FAIL reset_flags: ready/wr/busy/done/err/hold=%b required 000001",
                  {bready, wr_en, busy, done, err, hold});
      end
      n_cmp++;
      if ({addr, wdata, words} !== 80'h0) begin
         n_fail++;
         $display("FAIL reset_regs: addr=%h data=%h words=%0d required 0", addr, wdata, words);
      end
      n_cmp++;
      if (state_dbg !== IDLE) begin
         n_fail++; $display("FAIL reset_state: state=%0d required IDLE", state_dbg);
      end
   endtask

   task automatic test_two_words();
      clear_sb();
      prog_q = '{32'h2008_0005, 32'h0000_0000};
      pulse_start();
      send_program(1'b0, 1'b0);
      bvalid = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (obs_q.size() !== 2) begin
         n_fail++; $display("FAIL two_words_count: writes=%0d required 2", obs_q.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
               n_fail++; $display("FAIL two_words_wr%0d: addr/data=%h required %h", i, obs_q[i], exp_q[i]);
            end
            n_cmp++;
            if (obs_cyc[i] !== word_end_q[i] + 1 - 1) begin
               n_fail++; $display("FAIL two_words_timing%0d: write at edge %0d required edge after byte %0d",
                                  i, obs_cyc[i], word_end_q[i]);
            end
         end
      end
      n_cmp++;
      if ({done, hold, words} !== {1'b1, 1'b0, 16'd2}) begin
         n_fail++; $display("FAIL two_words_end: done=%b hold=%b words=%0d required 1 0 2", done, hold, words);
      end
   endtask

   task automatic test_zero_len();
      clear_sb();
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      bvalid = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({done, hold, words, 32'(obs_q.size())} !== {1'b1, 1'b0, 16'd0, 32'd0}) begin
         n_fail++; $display("FAIL zero_len: done=%b hold=%b words=%0d writes=%0d required 1 0 0 0",
                            done, hold, words, obs_q.size());
      end
   endtask

   task automatic test_oversize();
      clear_sb();
      pulse_start();
      send_byte(8'h01, 1'b0);
      send_byte(8'h04, 1'b0);
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({err, bready, hold, done, 32'(obs_q.size())} !== {1'b1, 1'b0, 1'b1, 1'b0, 32'd0}) begin
         n_fail++; $display("FAIL oversize: err=%b ready=%b hold=%b done=%b writes=%0d required 1 0 1 0 0",
                            err, bready, hold, done, obs_q.size());
      end
      bvalid = 1'b0;
      pulse_start();
      n_cmp++;
      if ({err, busy} !== 2'b01 || state_dbg !== LEN_LO) begin
         n_fail++; $display("FAIL err_restart: err=%b busy=%b state=%0d required 0 1 LEN_LO", err, busy, state_dbg);
      end
      // N = MAX_WORDS exactly is accepted
      send_byte(8'h00, 1'b0);
      send_byte(8'h04, 1'b0);
      bvalid = 1'b0;
      n_cmp++;
      if (err !== 1'b0 || state_dbg !== DATA) begin
         n_fail++; $display("FAIL max_words_accept: err=%b state=%0d required 0 DATA", err, state_dbg);
      end
      do_reset(1);
   endtask

   task automatic test_gapped();
      clear_sb();
      prog_q = '{$urandom()};
      pulse_start();
      send_program(1'b1, 1'b0);
      bdata = 8'hA5;
      n_cmp++;
      if ({wr_en, bready} !== 2'b10 || state_dbg !== WRITE) begin
         n_fail++; $display("FAIL gapped_write_cycle: wr_en=%b ready=%b state=%0d required 1 0 WRITE",
                            wr_en, bready, state_dbg);
      end
      @(negedge clk);
      n_cmp++;
      if ({done, busy, words} !== {1'b1, 1'b0, 16'd1}) begin
         n_fail++; $display("FAIL gapped_not_consumed: done=%b busy=%b words=%0d required 1 0 1", done, busy, words);
      end
      bvalid = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
         n_fail++; $display("FAIL gapped_write: writes=%0d first=%h required 1 %h",
                            obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'h0, exp_q[0]);
      end
   endtask

   task automatic test_reset_mid_load();
      clear_sb();
      pulse_start();
      send_byte(8'h03, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      bvalid = 1'b0;
      do_reset(1);
      n_cmp++;
      if (state_dbg !== IDLE || {hold, busy, words} !== {1'b1, 1'b0, 16'd0}) begin
         n_fail++; $display("FAIL mid_reset_state: state=%0d hold=%b busy=%b words=%0d required IDLE 1 0 0",
                            state_dbg, hold, busy, words);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (obs_q.size() !== 0) begin
         n_fail++; $display("FAIL mid_reset_nowrite: writes=%0d required 0", obs_q.size());
      end
      prog_q = '{$urandom()};
      pulse_start();
      send_program(1'b0, 1'b0);
      bvalid = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
         n_fail++; $display("FAIL mid_reset_reload: writes=%0d first=%h required 1 %h",
                            obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'h0, exp_q[0]);
      end
   endtask

   task automatic test_start_ignored();
      logic [31:0] w0;
      clear_sb();
      w0 = $urandom();
      prog_q = '{w0, $urandom()};
      exp_q.push_back({BASE, w0});
      exp_q.push_back({BASE + 32'd4, prog_q[1]});
      pulse_start();
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(w0[7:0], 1'b0);
      send_byte(w0[15:8], 1'b0);
      bvalid = 1'b0;
      pulse_start();
      send_byte(w0[23:16], 1'b0);
      send_byte(w0[31:24], 1'b0);
      for (int k = 0; k < 4; k++) send_byte(prog_q[1][8*k +: 8], 1'b0);
      bvalid = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (obs_q.size() !== 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1] || done !== 1'b1) begin
         n_fail++; $display("FAIL start_ignored: writes=%0d done=%b required 2 words %h %h and done=1",
                            obs_q.size(), done, exp_q[0], exp_q[1]);
      end
      clear_sb();
      prog_q = '{$urandom()};
      pulse_start();
      n_cmp++;
      if (words !== 16'd0) begin
         n_fail++; $display("FAIL restart_clear: words=%0d required 0", words);
      end
      send_program(1'b0, 1'b0);
      bvalid = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (words !== 16'd1 || obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
         n_fail++; $display("FAIL restart_load: words=%0d writes=%0d required 1 1 at %h", words, obs_q.size(), exp_q[0]);
      end
   endtask

   task automatic test_random();
      logic [15:0] big;
      for (int it = 0; it < 8; it++) begin
         clear_sb();
         pulse_start();
         if (it % 4 == 3) begin
            big = 16'($urandom_range(1025, 65535));
            send_byte(big[7:0], 1'b0);
            send_byte(big[15:8], 1'b0);
            bvalid = 1'b0;
            repeat (3) @(negedge clk);
            n_cmp++;
            if ({err, done, 32'(obs_q.size())} !== {1'b1, 1'b0, 32'd0}) begin
               n_fail++; $display("FAIL rand_oversize%0d: n=%0d err=%b done=%b writes=%0d required 1 0 0",
                                  it, big, err, done, obs_q.size());
            end
         end else begin
            prog_q.delete();
            for (int i = 0; i < $urandom_range(1, 6); i++) prog_q.push_back($urandom());
            send_program(1'b0, 1'b1);
            bvalid = 1'b0;
            repeat (3) @(negedge clk);
            n_cmp++;
            if (obs_q.size() !== exp_q.size()) begin
               n_fail++; $display("FAIL rand_count%0d: writes=%0d required %0d", it, obs_q.size(), exp_q.size());
            end else begin
               for (int i = 0; i < exp_q.size(); i++) begin
                  n_cmp++;
                  if (obs_q[i] !== exp_q[i] || obs_cyc[i] !== word_end_q[i]) begin
                     n_fail++; $display("FAIL rand_wr%0d_%0d: addr/data=%h at %0d required %h at %0d",
                                        it, i, obs_q[i], obs_cyc[i], exp_q[i], word_end_q[i]);
                  end
                  if (i > 0) begin
                     n_cmp++;
                     if (obs_cyc[i] - obs_cyc[i-1] < 5) begin
                        n_fail++; $display("FAIL rand_spacing%0d_%0d: gap=%0d required >=5",
                                           it, i, obs_cyc[i] - obs_cyc[i-1]);
                     end
                  end
               end
            end
            n_cmp++;
            if ({done, hold, words} !== {1'b1, 1'b0, 16'(exp_q.size())}) begin
               n_fail++; $display("FAIL rand_end%0d: done=%b hold=%b words=%0d required 1 0 %0d",
                                  it, done, hold, words, exp_q.size());
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; bvalid = 1'b0; bdata = 8'h00;
      @(negedge clk);
      test_reset();
      test_two_words();
      test_zero_len();
      test_oversize();
      test_gapped();
      test_reset_mid_load();
      test_start_ignored();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
